fsm_lock_param: RTL and testbench
=================================

# fsm_lock_param

Parametrised keypad lock FSM, the successor to the fixed 4-step pattern lock. It collects an N-digit code on a valid strobe and judges it only after the last digit, so it never reveals which digit was wrong. It counts consecutive failures and enforces a timed lockout, and holds the unlocked state for a bounded time. It drives the board's 7-segment display, green/red LEDs and debug state bus.

## Interface
- `W`, 4: digit width in bits.
- `N`, 4: code length in digits (N ≥ 1, N ≤ 15).
- `DEFAULT_CODE`, {4'h4,4'h3,4'h2,4'h1}: N*W-bit code; digit 0 is in the LSBs and is entered first.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout (≥ 1).
- `LOCK_CYCLES`, 100: lockout duration in clocks (≥ 1).
- `UNLOCK_CYCLES`, 50: unlocked hold time in clocks (≥ 1).
- `ENTRY_TIMEOUT`, 200: idle clocks allowed mid-entry before abort (≥ 1).
- `clk`, in, 1: single clock, all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_pattern`, in, W: digit, sampled only when `in_valid`=1.
- `in_valid`, in, 1: one-cycle digit strobe; each high cycle is one digit.
- `prog`, in, 1: code-program request; exists only with `FSM_LOCK_PROG_EN`.
- `seg`, out, 7: {g,f,e,d,c,b,a}, active-high.
- `green_led`, out, 1: high in UNLOCKED.
- `red_led`, out, 1: high in FAIL and LOCKOUT.
- `lockout`, out, 1: high in LOCKOUT.
- `fail_cnt`, out, $clog2(MAX_FAIL+1): consecutive-failure count.
- `state`, out, 4: IDLE=0, ENTRY=1, UNLOCKED=2, FAIL=3, LOCKOUT=4, PROG=5.

## Operation
- Reset values: state=IDLE, digit index=0, mismatch flag=0, `fail_cnt`=0, timers=0, `green_led`=0, `red_led`=0, `lockout`=0, `seg`=7'b0111111 ('0'). Reset also restores the code register to DEFAULT_CODE.
- IDLE, `in_valid`: compare the digit with code[0] and set the mismatch flag on difference.
  - If N=1, go straight to the judge step.
  - Otherwise go to ENTRY with index=1.
- ENTRY, `in_valid`: OR (digit != code[index]) into the mismatch flag and increment index.
  - On the Nth digit, judge: flag clear → UNLOCKED; flag set → FAIL.
  - The flag and index clear on leaving ENTRY.
- ENTRY timeout: after ENTRY_TIMEOUT consecutive cycles without `in_valid`, go to IDLE. `fail_cnt` is unchanged.
- UNLOCKED: clear `fail_cnt` on entry, then hold UNLOCK_CYCLES cycles and return to IDLE. `in_valid` is ignored, except as described in Configuration.
- FAIL: lasts exactly 1 cycle and increments `fail_cnt` (saturating).
  - Next state is LOCKOUT if the new count equals MAX_FAIL, otherwise IDLE.
- LOCKOUT: hold LOCK_CYCLES cycles; `in_valid` is ignored. On exit, clear `fail_cnt` and go to IDLE.
- `seg` display:
  - IDLE/ENTRY: hex of digits entered so far (0..N), standard decoding (1=7'b0000110, 2=7'b1011011, 3=7'b1001111, 4=7'b1100110).
  - UNLOCKED: 'U'=7'b0111110.
  - FAIL/LOCKOUT: 'E'=7'b1111001.
  - PROG: 'P'=7'b1110011.

## Timing
- All outputs are registered and decode from the current state and registers.
- Nth digit strobed in cycle k: UNLOCKED or FAIL is visible after edge k, so `green_led`/`red_led` rise in cycle k+1.
- UNLOCKED is visible for exactly UNLOCK_CYCLES cycles.
- LOCKOUT is visible for exactly LOCK_CYCLES cycles, starting the cycle after FAIL.
- Back-to-back `in_valid` is legal; each cycle consumes one digit.
- `rst` has priority over every event, including `in_valid` in the same cycle and mid-lockout.

## Configuration
- `FSM_LOCK_PROG_EN` defined:
  - The `prog` port exists and the code register is writable.
  - In UNLOCKED, `prog`=1 with `in_valid`=1 enters PROG; that digit is not stored.
  - The next N strobes write code[0..N-1] in order, then the FSM goes to IDLE.
  - ENTRY_TIMEOUT applies in PROG. On timeout the old code is kept and the FSM goes to IDLE.
- Undefined: no `prog` port, the code is the constant DEFAULT_CODE, and state 5 is unreachable.

## Test plan
- Defaults; strobe 1,2,3,4 → `state`=2 and `green_led`=1 for 50 cycles, then `state`=0; `fail_cnt`=0.
- Strobe 1,9,3,4 → no reaction until the 4th digit, then `state`=3 for 1 cycle, `red_led`=1, `fail_cnt`=1, then IDLE.
- Three wrong codes → `lockout`=1 for 100 cycles; correct code strobed during lockout is ignored; afterwards `fail_cnt`=0.
- Strobe 1,2, then wait 200 cycles → `state`=0, `seg`='0', `fail_cnt` unchanged; `rst` asserted mid-lockout → all outputs return to reset values on the next edge.
- With `FSM_LOCK_PROG_EN`: unlock, then `prog`+strobe, write 5,6,7,8 → code 1,2,3,4 now fails and 5,6,7,8 unlocks. After `rst`, 1,2,3,4 unlocks again.

Source files
------------

// File: rtl/fsm_lock_param.sv
// rtl/fsm_lock_param.sv - parametrised keypad lock FSM with failure lockout
// Code programming from UNLOCKED is compiled in when FSM_LOCK_PROG_EN is defined.
module fsm_lock_param #(
  parameter int W = 4,
  parameter int N = 4,
  parameter logic [N*W-1:0] DEFAULT_CODE = {4'h4, 4'h3, 4'h2, 4'h1},
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYCLES = 100,
  parameter int UNLOCK_CYCLES = 50,
  parameter int ENTRY_TIMEOUT = 200
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [W-1:0]                  in_pattern,
  input  logic                          in_valid,
`ifdef FSM_LOCK_PROG_EN
  input  logic                          prog,
`endif
  output logic [6:0]                    seg,
  output logic                          green_led,
  output logic                          red_led,
  output logic                          lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
  output logic [3:0]                    state
);

  localparam int FW     = $clog2(MAX_FAIL + 1);
  localparam int T_MAX0 = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
  localparam int T_MAX  = (T_MAX0 > ENTRY_TIMEOUT) ? T_MAX0 : ENTRY_TIMEOUT;
  localparam int TW     = $clog2(T_MAX + 1);

  localparam logic [3:0]    LAST_IDX = 4'(N - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
  localparam logic [TW-1:0] UL_LAST  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LK_LAST  = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ENTRY_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ENTRY    = 4'd1,
    S_UNLOCKED = 4'd2,
    S_FAIL     = 4'd3,
    S_LOCKOUT  = 4'd4,
    S_PROG     = 4'd5
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic            mis_q, mis_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [N*W-1:0]  code_q;
  logic [W-1:0]    exp_digit;
  logic            digit_bad;

`ifdef FSM_LOCK_PROG_EN
  logic [N*W-1:0]  code_d, buf_q, buf_d;
`else
  assign code_q = DEFAULT_CODE;
`endif

  assign exp_digit = code_q[int'(idx_q)*W +: W];
  assign digit_bad = (in_pattern != exp_digit);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    tmr_d   = tmr_q;
    fcnt_d  = fcnt_q;
`ifdef FSM_LOCK_PROG_EN
    buf_d   = buf_q;
    code_d  = code_q;
`endif
    case (state_q)
      // IDLE always holds idx=0 and a clear flag, so both states share one path
      S_IDLE, S_ENTRY: begin
        if (in_valid) begin
          tmr_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            mis_d = 1'b0;
            if (mis_q | digit_bad) begin
              state_d = S_FAIL;
              fcnt_d  = (fcnt_q == FAIL_MAX) ? fcnt_q : fcnt_q + 1'b1;
            end else begin
              state_d = S_UNLOCKED;
              fcnt_d  = '0;
            end
          end else begin
            state_d = S_ENTRY;
            idx_d   = idx_q + 4'd1;
            mis_d   = mis_q | digit_bad;
          end
        end else if (state_q == S_ENTRY) begin
          if (tmr_q == TO_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            mis_d   = 1'b0;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      S_UNLOCKED: begin
        if (tmr_q == UL_LAST) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
`ifdef FSM_LOCK_PROG_EN
        if (prog && in_valid) begin
          state_d = S_PROG;
          tmr_d   = '0;
          idx_d   = '0;
        end
`endif
      end
      S_FAIL: begin
        state_d = (fcnt_q == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
        tmr_d   = '0;
      end
      S_LOCKOUT: begin
        if (tmr_q == LK_LAST) begin
          state_d = S_IDLE;
          tmr_d   = '0;
          fcnt_d  = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`ifdef FSM_LOCK_PROG_EN
      // digits collect in a shadow buffer so an aborted entry keeps the old code
      S_PROG: begin
        if (in_valid) begin
          tmr_d = '0;
          buf_d[int'(idx_q)*W +: W] = in_pattern;
          if (idx_q == LAST_IDX) begin
            code_d  = buf_d;
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (tmr_q == TO_LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        mis_d   = 1'b0;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      tmr_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      tmr_q   <= tmr_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef FSM_LOCK_PROG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= DEFAULT_CODE;
      buf_q  <= DEFAULT_CODE;
    end else begin
      code_q <= code_d;
      buf_q  <= buf_d;
    end
  end
`endif

  always_comb begin
    green_led = (state_q == S_UNLOCKED);
    red_led   = (state_q == S_FAIL) || (state_q == S_LOCKOUT);
    lockout   = (state_q == S_LOCKOUT);
    case (state_q)
      S_IDLE, S_ENTRY:    seg = hex7(idx_q);
      S_UNLOCKED:         seg = 7'b0111110;
      S_FAIL, S_LOCKOUT:  seg = 7'b1111001;
      S_PROG:             seg = 7'b1110011;
      default:            seg = 7'b0111111;
    endcase
  end

  assign fail_cnt = fcnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_fsm_lock_param.sv
// tb/tb_fsm_lock_param.sv - self-checking bench for fsm_lock_param
// Vector table, hand-written corner sequences and randomized run against a reference model.
module tb_fsm_lock_param;

  localparam int W = 4;
  localparam int N = 4;
  localparam int MAX_FAIL = 3;
  localparam int LOCK_CYCLES = 100;
  localparam int UNLOCK_CYCLES = 50;
  localparam int ENTRY_TIMEOUT = 200;
  localparam int FW = $clog2(MAX_FAIL + 1);
`ifdef FSM_LOCK_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, prog_i;
  logic [W-1:0]  in_pattern;
  logic [6:0]    seg;
  logic          green_led, red_led, lockout;
  logic [FW-1:0] fail_cnt;
  logic [3:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fsm_lock_param #(
    .W(W), .N(N), .DEFAULT_CODE({4'h4, 4'h3, 4'h2, 4'h1}), .MAX_FAIL(MAX_FAIL),
    .LOCK_CYCLES(LOCK_CYCLES), .UNLOCK_CYCLES(UNLOCK_CYCLES), .ENTRY_TIMEOUT(ENTRY_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_pattern(in_pattern), .in_valid(in_valid),
`ifdef FSM_LOCK_PROG_EN
    .prog(prog_i),
`endif
    .seg(seg), .green_led(green_led), .red_led(red_led), .lockout(lockout),
    .fail_cnt(fail_cnt), .state(state)
  );

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // reference model: digits kept in a queue and judged as a whole code
  int           m_state, m_fail, m_timer;
  logic [W-1:0] entered [$];
  logic [W-1:0] m_code [N];

  task automatic model_step(input logic r, input logic v, input logic [W-1:0] d, input logic p);
    bit ok;
    if (r) begin
      m_state = 0; m_fail = 0; m_timer = 0; entered.delete();
      for (int i = 0; i < N; i++) m_code[i] = W'(i + 1);
      return;
    end
    case (m_state)
      0, 1: begin
        if (v) begin
          entered.push_back(d);
          m_timer = 0;
          if (entered.size() == N) begin
            ok = 1'b1;
            for (int i = 0; i < N; i++) if (entered[i] != m_code[i]) ok = 1'b0;
            entered.delete();
            if (ok) begin m_state = 2; m_fail = 0; end
            else begin m_state = 3; if (m_fail < MAX_FAIL) m_fail++; end
          end else m_state = 1;
        end else if (m_state == 1) begin
          m_timer++;
          if (m_timer == ENTRY_TIMEOUT) begin m_state = 0; m_timer = 0; entered.delete(); end
        end
      end
      2: begin
        m_timer++;
        if (PROG_EN && p && v) begin m_state = 5; m_timer = 0; entered.delete(); end
        else if (m_timer == UNLOCK_CYCLES) begin m_state = 0; m_timer = 0; end
      end
      3: begin m_state = (m_fail == MAX_FAIL) ? 4 : 0; m_timer = 0; end
      4: begin
        m_timer++;
        if (m_timer == LOCK_CYCLES) begin m_state = 0; m_timer = 0; m_fail = 0; end
      end
      default: begin
        if (v) begin
          entered.push_back(d);
          m_timer = 0;
          if (entered.size() == N) begin
            for (int i = 0; i < N; i++) m_code[i] = entered[i];
            entered.delete();
            m_state = 0;
          end
        end else begin
          m_timer++;
          if (m_timer == ENTRY_TIMEOUT) begin m_state = 0; m_timer = 0; entered.delete(); end
        end
      end
    endcase
  endtask

  function automatic logic [31:0] pack(input logic [3:0] st, input logic g, input logic r,
                                       input logic l, input logic [FW-1:0] f, input logic [6:0] s);
    return 32'({st, g, r, l, f, s});
  endfunction

  function automatic logic [31:0] model_pack();
    logic [6:0] s;
    case (m_state)
      0, 1:    s = hex_tbl[entered.size()];
      2:       s = 7'h3E;
      3, 4:    s = 7'h79;
      default: s = 7'h73;
    endcase
    return pack(4'(m_state), m_state == 2, m_state == 3 || m_state == 4, m_state == 4, FW'(m_fail), s);
  endfunction

  function automatic logic [31:0] dut_pack();
    return pack(state, green_led, red_led, lockout, fail_cnt, seg);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d, input logic p);
    rst = r; in_valid = v; in_pattern = d; prog_i = p;
    model_step(r, v, d, p);
    @(posedge clk);
    #1;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] e);
    cyc(0, 1, a, 0); cyc(0, 1, b, 0); cyc(0, 1, c, 0); cyc(0, 1, e, 0);
  endtask

  typedef struct {
    logic r; logic v; logic [3:0] d;
    logic [3:0] st; logic g; logic rd; logic lk; logic [FW-1:0] fc; logic [6:0] sg;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d, input logic [3:0] st,
                              input logic g, input logic rd, input logic lk, input logic [FW-1:0] fc,
                              input logic [6:0] sg);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.st = st; t.g = g; t.rd = rd; t.lk = lk; t.fc = fc; t.sg = sg;
    return t;
  endfunction

  vec_t tbl [$];

  initial begin
    int n, k;
    logic v, p;
    logic [W-1:0] d;
    rst = 1'b1; in_valid = 1'b0; in_pattern = '0; prog_i = 1'b0;

    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'h3F));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 7'h06));
    tbl.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0, 7'h5B));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 7'h5B));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 7'h4F));
    tbl.push_back(mk(0, 1, 4, 2, 1, 0, 0, 0, 7'h3E));
    tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0, 0, 7'h3E));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'h3F));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 7'h06));
    tbl.push_back(mk(0, 1, 9, 1, 0, 0, 0, 0, 7'h5B));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 7'h4F));
    tbl.push_back(mk(0, 1, 4, 3, 0, 1, 0, 1, 7'h79));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7'h3F));
    tbl.push_back(mk(0, 1, 4, 1, 0, 0, 0, 1, 7'h06));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 7'h3F));

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].d, 0);
      chk($sformatf("vec%0d", i), dut_pack(),
          pack(tbl[i].st, tbl[i].g, tbl[i].rd, tbl[i].lk, tbl[i].fc, tbl[i].sg));
    end

    // unlocked hold length
    cyc(1, 0, 0, 0);
    enter4(1, 2, 3, 4);
    n = 0;
    while (state == 4'd2 && n < 100) begin n++; cyc(0, 0, 0, 0); end
    chk("unlock_len", 32'(n), 32'(UNLOCK_CYCLES));
    chk("unlock_exit", dut_pack(), pack(0, 0, 0, 0, 0, 7'h3F));

    // three failures, lockout ignores a correct code
    cyc(1, 0, 0, 0);
    enter4(1, 9, 3, 4); cyc(0, 0, 0, 0);
    enter4(5, 2, 3, 4); cyc(0, 0, 0, 0);
    enter4(1, 2, 3, 5);
    chk("third_fail", dut_pack(), pack(3, 0, 1, 0, FW'(MAX_FAIL), 7'h79));
    cyc(0, 0, 0, 0);
    n = 0; k = 0;
    while (lockout && n < 200) begin
      n++;
      cyc(0, k < 4, W'(k + 1), 0);
      k++;
    end
    chk("lockout_len", 32'(n), 32'(LOCK_CYCLES));
    chk("lockout_exit", dut_pack(), pack(0, 0, 0, 0, 0, 7'h3F));

    // entry timeout keeps the failure count
    cyc(1, 0, 0, 0);
    enter4(1, 9, 3, 4); cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0); cyc(0, 1, 2, 0);
    repeat (ENTRY_TIMEOUT - 1) cyc(0, 0, 0, 0);
    chk("timeout_early", 32'(state), 32'd1);
    cyc(0, 0, 0, 0);
    chk("timeout_abort", dut_pack(), pack(0, 0, 0, 0, 1, 7'h3F));

    // reset mid-lockout wins over a same-cycle strobe
    cyc(1, 0, 0, 0);
    repeat (3) begin enter4(9, 9, 9, 9); cyc(0, 0, 0, 0); end
    repeat (10) cyc(0, 0, 0, 0);
    chk("in_lockout", 32'(lockout), 32'd1);
    cyc(1, 1, 1, 0);
    chk("rst_lockout", dut_pack(), pack(0, 0, 0, 0, 0, 7'h3F));

`ifdef FSM_LOCK_PROG_EN
    enter4(1, 2, 3, 4);
    cyc(0, 1, 9, 1);
    chk("prog_enter", dut_pack(), pack(5, 0, 0, 0, 0, 7'h73));
    enter4(5, 6, 7, 8);
    chk("prog_done", 32'(state), 32'd0);
    enter4(1, 2, 3, 4);
    chk("old_code_fails", 32'(state), 32'd3);
    cyc(0, 0, 0, 0);
    enter4(5, 6, 7, 8);
    chk("new_code_opens", 32'(state), 32'd2);
    cyc(1, 0, 0, 0);
    enter4(1, 2, 3, 4);
    chk("rst_restores", 32'(state), 32'd2);
`endif

    // randomized run against the model
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      case ((i / 300) % 3)
        0:       v = ($urandom_range(9) < 6);
        1:       v = ($urandom_range(9) < 2);
        default: v = ((i % 300) < 2);
      endcase
      if ((m_state <= 1 || m_state == 5) && entered.size() < N && $urandom_range(4) != 0)
        d = m_code[entered.size()];
      else
        d = W'($urandom_range(15));
      p = PROG_EN && ($urandom_range(7) == 0);
      cyc($urandom_range(699) == 0, v, d, p);
      chk("rand", dut_pack(), model_pack());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
